hex_display_scan: RTL and testbench

//  Parametrised multi-digit time-multiplexed hex display driver; successor to the single-digit 7-seg top.

---
 rtl/hex_display_scan.sv | 161 ++++++++++++++++
 tb/tb_hex_display_scan.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/hex_display_scan.sv
// hex_display_scan: time-multiplexed multi-digit hex display driver.
// Captures ResultW on a valid strobe into a shadow register and scans it
// one nibble per digit slot across NUM_DIGITS common-anode digits.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks leading zero digits
// (digit 0 always shown).
module hex_display_scan #(
   parameter int NUM_DIGITS     = 8,
   parameter int DATA_W         = 32,
   parameter int REFRESH_DIV    = 100000,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit AN_ACTIVE_LOW  = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_W-1:0]     ResultW,
   input  logic                  ResultValid,
   input  logic                  hold,
   output logic [6:0]            display,
   output logic [NUM_DIGITS-1:0] anode
);

   localparam int SHW_W = 4 * NUM_DIGITS;
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int PRE_W = $clog2(REFRESH_DIV);
   localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_DIGITS - 1);
   localparam logic [PRE_W-1:0]      LAST_PRE = PRE_W'(REFRESH_DIV - 1);
   localparam logic [6:0]            SEG_OFF  = {7{SEG_ACTIVE_LOW}};
   localparam logic [NUM_DIGITS-1:0] AN_OFF   = {NUM_DIGITS{AN_ACTIVE_LOW}};

   typedef enum logic {S_IDLE, S_SCAN} state_t;

   state_t                          r_state, w_state_nxt;
   logic [SHW_W-1:0]                r_shadow;
   logic [SHW_W-1:0]                w_ext;
   logic [NUM_DIGITS-1:0][3:0]      w_nib;
   logic [PRE_W-1:0]                r_presc;
   logic                            w_tick;
   logic [IDX_W-1:0]                r_idx, w_idx_nxt;
   logic [6:0]                      w_seg_on, w_disp_nxt, r_display;
   logic [NUM_DIGITS-1:0]           w_an_on, w_an_nxt, r_anode;
   logic                            w_blank;

   // Active-high glyph {g,f,e,d,c,b,a}; b and d are lowercase.
   function automatic logic [6:0] f_glyph(input logic [3:0] n);
      case (n)
         4'h0: f_glyph = 7'h3F;
         4'h1: f_glyph = 7'h06;
         4'h2: f_glyph = 7'h5B;
         4'h3: f_glyph = 7'h4F;
         4'h4: f_glyph = 7'h66;
         4'h5: f_glyph = 7'h6D;
         4'h6: f_glyph = 7'h7D;
         4'h7: f_glyph = 7'h07;
         4'h8: f_glyph = 7'h7F;
         4'h9: f_glyph = 7'h6F;
         4'hA: f_glyph = 7'h77;
         4'hB: f_glyph = 7'h7C;
         4'hC: f_glyph = 7'h39;
         4'hD: f_glyph = 7'h5E;
         4'hE: f_glyph = 7'h79;
         default: f_glyph = 7'h71;
      endcase
   endfunction

   // Zero-extend ResultW to the full digit width; missing upper nibbles read 0.
   always_comb begin
      w_ext = '0;
      w_ext[DATA_W-1:0] = ResultW;
   end

   assign w_nib = r_shadow;

   // Shadow capture; hold freezes the displayed value and drops strobes.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                        r_shadow <= '0;
      else if (ResultValid && !hold)   r_shadow <= w_ext;
   end

   assign w_tick = (r_presc == LAST_PRE);

   // Slot prescaler: 0..REFRESH_DIV-1, tick on the last count.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)        r_presc <= '0;
      else if (w_tick) r_presc <= '0;
      else             r_presc <= r_presc + 1'b1;
   end

   // Scan FSM state and digit index registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_idx   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
      end
   end

   // Next state / next index: IDLE leaves on the first tick with index 0,
   // SCAN advances and wraps the index on every tick.
   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      unique case (r_state)
         S_IDLE: begin
            if (w_tick) begin
               w_state_nxt = S_SCAN;
               w_idx_nxt   = '0;
            end
         end
         S_SCAN: begin
            if (w_tick)
               w_idx_nxt = (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

`ifdef LEADING_ZERO_BLANK_EN
   logic [NUM_DIGITS-1:0] w_upper_zero;   // bit i: nibbles i..NUM_DIGITS-1 all zero

   // Suffix-AND of per-nibble zero flags from the top digit down.
   always_comb begin
      w_upper_zero = '0;
      w_upper_zero[NUM_DIGITS-1] = (w_nib[NUM_DIGITS-1] == 4'h0);
      for (int i = NUM_DIGITS - 2; i >= 0; i--)
         w_upper_zero[i] = w_upper_zero[i+1] && (w_nib[i] == 4'h0);
   end

   assign w_blank = (w_idx_nxt != '0) && w_upper_zero[w_idx_nxt];
`else
   assign w_blank = 1'b0;
`endif

   assign w_seg_on   = f_glyph(w_nib[w_idx_nxt]);
   assign w_disp_nxt = w_blank ? SEG_OFF
                               : (SEG_ACTIVE_LOW ? ~w_seg_on : w_seg_on);

   // One-hot enable for the digit about to be shown.
   always_comb begin
      w_an_on = '0;
      w_an_on[w_idx_nxt] = 1'b1;
   end

   assign w_an_nxt = AN_ACTIVE_LOW ? ~w_an_on : w_an_on;

   // Anode and segments load together on the tick edge so they never skew.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_display <= SEG_OFF;
         r_anode   <= AN_OFF;
      end else if (w_tick) begin
         r_display <= w_disp_nxt;
         r_anode   <= w_an_nxt;
      end
   end

   assign display = r_display;
   assign anode   = r_anode;

endmodule

// File: tb/tb_hex_display_scan.sv
// Bench for hex_display_scan: NUM_DIGITS=8, DATA_W=32, REFRESH_DIV=4.
// A second instance with both polarities active-high shares the inputs.
module tb_hex_display_scan;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] ResultW;
   logic        ResultValid;
   logic        hold;
   logic [6:0]  display, dispP;
   logic [7:0]  anode, anP;

   always #5 clk = ~clk;

   hex_display_scan #(.NUM_DIGITS(8), .DATA_W(32), .REFRESH_DIV(4),
                      .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) u_dut (
      .clk(clk), .rst(rst), .ResultW(ResultW), .ResultValid(ResultValid),
      .hold(hold), .display(display), .anode(anode));

   hex_display_scan #(.NUM_DIGITS(8), .DATA_W(32), .REFRESH_DIV(4),
                      .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)) u_pol (
      .clk(clk), .rst(rst), .ResultW(ResultW), .ResultValid(ResultValid),
      .hold(hold), .display(dispP), .anode(anP));

   typedef struct {
      logic [7:0] an;
      logic [6:0] disp;
      int         dig;
   } exp_t;

   typedef struct {
      logic [31:0] val;
      logic        valid;
      logic        hld;
      logic [31:0] shown;
   } vec_t;

   exp_t       sb_q[$];
   vec_t       vecs[9];
   int         checks = 0;
   int         fails  = 0;
   logic [7:0] prev_an = 8'hFF;
   int         len = 0;
   bit         have_prev = 1'b0;
   int         first;

   // Active-low hex glyphs {g,f,e,d,c,b,a}.
   function automatic logic [6:0] glyph(input logic [3:0] n);
      case (n)
         4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;
         4'h3: return 7'h30;  4'h4: return 7'h19;  4'h5: return 7'h12;
         4'h6: return 7'h02;  4'h7: return 7'h78;  4'h8: return 7'h00;
         4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
         4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;
         default: return 7'h0E;
      endcase
   endfunction

   function automatic logic [6:0] exp_disp(input logic [31:0] v, input int i);
      logic [31:0] up;
      up = v >> (4 * i);
`ifdef LEADING_ZERO_BLANK_EN
      if (i > 0 && up == 32'h0) return 7'h7F;
`endif
      return glyph(up[3:0]);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic push_digit(input logic [31:0] v, input int i);
      exp_t e;
      e.an   = ~(8'h01 << i);
      e.disp = exp_disp(v, i);
      e.dig  = i;
      sb_q.push_back(e);
   endtask

   // One clock; on every anode change check slot length and pop the scoreboard.
   task automatic step();
      @(negedge clk);
      if (!rst) begin
         have_prev = 1'b0;
         prev_an   = anode;
         len       = 0;
         return;
      end
      if (anode != prev_an) begin
         if (have_prev) chk("slot_len", len, 4);
         have_prev = 1'b1;
         len       = 1;
         if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            chk($sformatf("anode_d%0d", e.dig), anode, e.an);
            chk($sformatf("display_d%0d", e.dig), display, e.disp);
         end
      end else begin
         len++;
      end
      prev_an = anode;
   endtask

   // Align to the negedge right after digit 7's slot begins.
   task automatic sync_slot7();
      int n;
      n = 0;
      while (anode == 8'h7F && n < 64) begin step(); n++; end
      while (anode != 8'h7F && n < 64) begin step(); n++; end
      if (n >= 64) begin
         checks++; fails++;
         $display("FAIL sync_slot7 actual=%h required=7f", anode);
      end
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while (sb_q.size() > 0 && n < budget) begin step(); n++; end
      if (sb_q.size() > 0) begin
         checks++; fails++;
         $display("FAIL drain_timeout actual=%0d required=0 pending", sb_q.size());
         sb_q.delete();
      end
   endtask

   initial begin
      vecs[0] = '{32'h76543210, 1'b1, 1'b0, 32'h76543210};
      vecs[1] = '{32'hDEADBEEF, 1'b1, 1'b0, 32'hDEADBEEF};
      vecs[2] = '{32'h00000000, 1'b1, 1'b1, 32'hDEADBEEF};
      vecs[3] = '{32'h000000A5, 1'b1, 1'b0, 32'h000000A5};
      vecs[4] = '{32'h00000000, 1'b1, 1'b0, 32'h00000000};
      vecs[5] = '{32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF};
      vecs[6] = '{32'h89ABCDEF, 1'b0, 1'b0, 32'hFFFFFFFF};
      vecs[7] = '{32'h89ABCDEF, 1'b1, 1'b0, 32'h89ABCDEF};
      vecs[8] = '{32'h00000000, 1'b1, 1'b0, 32'h00000000};

      rst = 1'b0; ResultW = '0; ResultValid = 1'b0; hold = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_anode", anode, 8'hFF);
      chk("reset_display", display, 7'h7F);
      chk("reset_anode_pol", anP, 8'h00);
      chk("reset_display_pol", dispP, 7'h00);

      // Release with 8 strobed immediately; first enable 4 clocks later.
      @(negedge clk);
      rst = 1'b1; ResultW = 32'h8; ResultValid = 1'b1;
      push_digit(32'h8, 0);
      first = 0;
      for (int k = 1; k <= 8; k++) begin
         step();
         if (k == 1) ResultValid = 1'b0;
         if (k == 3) chk("idle_off", anode, 8'hFF);
         if (first == 0 && anode != 8'hFF) begin
            first = k;
            chk("pol_display", dispP, 7'h7F);
            chk("pol_anode", anP, 8'h01);
         end
      end
      chk("first_enable", first, 4);
      drain(64);

      // Table: strobe during slot 7, then expect a full scan of the shown value.
      for (int v = 0; v < 9; v++) begin
         sync_slot7();
         ResultW = vecs[v].val; ResultValid = vecs[v].valid; hold = vecs[v].hld;
         step();
         ResultValid = 1'b0; hold = 1'b0;
         for (int i = 0; i < 8; i++) push_digit(vecs[v].shown, i);
         drain(64);
      end

      // Strobe 1 exactly on digit 0's tick edge: old value shown this slot.
      sync_slot7();
      repeat (3) step();
      ResultW = 32'h1; ResultValid = 1'b1;
      push_digit(32'h0, 0);
      for (int i = 1; i < 8; i++) push_digit(32'h1, i);
      push_digit(32'h1, 0);
      step();
      ResultValid = 1'b0;
      drain(80);

      // Reset mid-slot: outputs off at once, shadow cleared, restart after 4.
      sync_slot7();
      repeat (2) step();
      rst = 1'b0;
      #1;
      chk("midreset_anode", anode, 8'hFF);
      chk("midreset_display", display, 7'h7F);
      chk("midreset_anode_pol", anP, 8'h00);
      step();
      rst = 1'b1;
      push_digit(32'h0, 0);
      first = 0;
      for (int k = 1; k <= 8; k++) begin
         step();
         if (first == 0 && anode != 8'hFF) first = k;
      end
      chk("reset_restart", first, 4);
      drain(64);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
